// File: rtl/mem_read_streamer_pkg.sv
// Shared types and constants for the memory read streamer: widths, the
// default image size, the controller state encoding and the burst range check.
package mem_read_streamer_pkg;

   localparam int ADDR_W        = 16;
   localparam int DATA_W        = 64;
   localparam int MEM_WORDS_DEF = 49152;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // The sum is formed one bit wider than an address so that a base near the
   // top of the 16-bit space cannot wrap and look in range.
   function automatic logic burst_fits(input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] len,
                                       input logic [31:0]       mem_words);
      logic [ADDR_W:0] end_excl;
      end_excl = {1'b0, base} + {1'b0, len};
      return (32'(end_excl) <= mem_words);
   endfunction

endpackage

// File: rtl/mem_read_streamer_fifo.sv
// Small first-word-fall-through FIFO: the head entry is always visible on
// o_data, and a push and pop in the same cycle leave the occupancy unchanged.
module stream_fifo #(
   parameter int  WIDTH = 64,
   parameter int  DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/mem_read_streamer.sv
// Streams a contiguous burst of words out of a synchronous-read image memory
// into a valid/ready output, throttled so the output buffer never overflows.
module mem_read_streamer
   import mem_read_streamer_pkg::*;
#(
   parameter int MEM_WORDS  = MEM_WORDS_DEF,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] baseAddress,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] memAddress,
   output logic              memWriteEnable,
   input  logic [DATA_W-1:0] memData,
   output logic [DATA_W-1:0] outData,
   output logic              outValid,
   input  logic              outReady
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int HELD_W = CNT_W + 1;

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] w_issue_addr;
   logic [ADDR_W-1:0] r_left;
   logic [ADDR_W-1:0] w_left_next;
   logic              r_addr_v;
   logic              r_data_v;
   logic              r_error;
   logic              w_issue;
   logic              w_error_next;

   logic [DATA_W-1:0] w_fifo_data;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [CNT_W-1:0]  w_fifo_count;
   logic              w_push;
   logic              w_pop;
   logic              w_accept;
   logic [HELD_W-1:0] w_held;

   // A returning word bypasses the buffer when it is empty and downstream is
   // ready; otherwise it queues behind older words to keep ordering.
   assign w_accept = outValid && outReady;
   assign w_pop    = !w_fifo_empty && outReady;
   assign w_push   = r_data_v && !(w_fifo_empty && outReady);

   // Words owned by the streamer once this cycle's handshake completes:
   // buffered, returning from memory, and addressed this cycle.
   assign w_held = HELD_W'(w_fifo_count) + HELD_W'(r_data_v)
                 + HELD_W'(r_addr_v) - HELD_W'(w_accept);

   stream_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (memData),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   always_comb begin
      w_state_next = r_state;
      w_issue      = 1'b0;
      w_issue_addr = r_mem_addr + 1'b1;
      w_left_next  = r_left;
      w_error_next = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (length == '0) begin
                  w_state_next = ST_DONE;
               end else if (burst_fits(baseAddress, length, 32'(MEM_WORDS))) begin
                  w_state_next = ST_RUN;
                  w_issue      = 1'b1;
                  w_issue_addr = baseAddress;
                  w_left_next  = length - 1'b1;
               end else begin
                  w_error_next = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (r_addr_v && (r_left == '0)) begin
               w_state_next = ST_DRAIN;
            end else if ((r_left != '0) && (w_held < HELD_W'(FIFO_DEPTH))
                         && !(w_fifo_full && !w_pop)) begin
               w_issue     = 1'b1;
               w_left_next = r_left - 1'b1;
            end
         end
         ST_DRAIN: begin
            if (w_held == '0) w_state_next = ST_DONE;
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_mem_addr <= '0;
         r_left     <= '0;
         r_addr_v   <= 1'b0;
         r_data_v   <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_left   <= w_left_next;
         r_addr_v <= w_issue;
         r_data_v <= r_addr_v;
         r_error  <= w_error_next;
         if (w_issue) r_mem_addr <= w_issue_addr;
      end
   end

   assign memAddress     = r_mem_addr;
   assign memWriteEnable = 1'b0;
   assign busy           = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign done           = (r_state == ST_DONE);
   assign error          = r_error;
   assign outValid       = !w_fifo_empty || r_data_v;
   assign outData        = !w_fifo_empty ? w_fifo_data : (r_data_v ? memData : '0);

endmodule

// File: doc/mem_read_streamer.md
MEM_READ_STREAMER -- requirements
Module: mem_read_streamer

Interface
REQ-001 SHALL expose parameter MEM_WORDS, default 49152: number of valid 64-bit words in the image memory.
REQ-002 SHALL expose parameter FIFO_DEPTH, default 2: output buffer entries, power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 baseAddress  input  16  first word address of the burst, captured on accepted start.
REQ-007 length  input  16  number of words in the burst, captured on accepted start.
REQ-008 busy  output  1  high from accepted start until done is asserted.
REQ-009 done  output  1  one-cycle pulse when the last word has been accepted downstream.
REQ-010 error  output  1  one-cycle pulse when start is rejected for an out-of-range burst.
REQ-011 memAddress  output  16  read address driven to the memory.
REQ-012 memWriteEnable  output  1  memory write strobe; constant 0.
REQ-013 memData  input  64  memory read data, valid one cycle after memAddress is presented.
REQ-014 outData  output  64  stream data word.
REQ-015 outValid  output  1  outData holds a valid word.
REQ-016 outReady  input  1  downstream accepts the word when outValid and outReady are both high.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE -> RUN on start when length != 0 and baseAddress+length <= MEM_WORDS, computed at 17 bits to avoid overflow.
REQ-019 IDLE -> DONE on start when length == 0; this SHALL issue no reads and pulse done on the next cycle.
REQ-020 IDLE on start with an out-of-range burst: SHALL stay in IDLE and pulse error for 1 cycle; busy SHALL stay low.
REQ-021 RUN: SHALL issue one read per cycle at baseAddress, baseAddress+1, ..., incrementing by 1 with no wrap.
- Each read is issued only if (FIFO occupancy + reads in flight) < FIFO_DEPTH.
REQ-022 RUN -> DRAIN in the cycle the last read (index length-1) is issued.
REQ-023 DRAIN -> DONE when the FIFO is empty and no read is in flight.
REQ-024 DONE -> IDLE unconditionally after 1 cycle; done SHALL be high in DONE only.
REQ-025 Each word returned on memData one cycle after issue SHALL be pushed into the FIFO; the FIFO SHALL never overflow.
REQ-026 outData/outValid SHALL come from the FIFO head; outData SHALL hold stable while outValid is high and outReady is low.
REQ-027 Latency: with outReady held high, the first word SHALL appear on outValid 2 cycles after start is accepted.
- Sustained throughput SHALL be 1 word per cycle.
REQ-028 Push and pop in the same cycle on a full or non-empty FIFO SHALL keep the occupancy unchanged and preserve word order.
REQ-029 start while busy SHALL be ignored.
REQ-030 memAddress SHALL hold its last value when no read is issued; memWriteEnable SHALL always be 0.
REQ-031 Words SHALL be delivered in ascending address order, exactly length words, with no duplicates or drops.

Reset
REQ-032 Reset SHALL return the FSM to IDLE and empty the FIFO.
REQ-033 Reset SHALL set busy, done, error and outValid to 0, and memAddress and outData to 0.
REQ-034 Reset mid-burst SHALL abort the burst; a read in flight at reset SHALL be discarded and not pushed.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, MEM_WORDS, and the address/data width constants (16, 64).
REQ-036 The output buffer SHALL be a separate sub-module, stream_fifo, parameterised by width and FIFO_DEPTH, with push/pop/full/empty/count.

Verification
REQ-037 start, base=0x0010, length=4, outReady=1 -> outData = mem[0x10..0x13] on 4 consecutive cycles from start+2, then done 1 cycle after the last word.
REQ-038 base=0x0000, length=8, outReady toggling 1,0,0,1,... -> all 8 words delivered in order; FIFO count never exceeds 2; no duplicates.
REQ-039 base=0xBFFE, length=2 -> reads 0xBFFE and 0xBFFF and done; base=0xBFFF, length=2 -> error pulse, busy stays 0, no reads issued.
REQ-040 length=0 -> done pulses 1 cycle after start; outValid never rises.
REQ-041 rst low after the 3rd of 10 words -> all outputs 0 within the same cycle; a subsequent start with base=0x0100, length=2 delivers only mem[0x100], mem[0x101].
REQ-042 start pulsed mid-burst -> ignored; exactly the original length words are delivered.
